multicycle_control_fsm: RTL and testbench

Sequencing controller for the multi-cycle MIPS datapath. It replaces single-cycle opcode decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and mux selects. A ready handshake with the shared instruction/data memory lets fetch and memory cycles stall.

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/mips_ctrl_outdec.sv | 73 +++++++
 rtl/multicycle_control_fsm.sv | 73 +++++++
 tb/tb_multicycle_control_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcode, state and control-field encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RT = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  typedef struct packed {
    logic pcWrite;
    logic pcWriteCond;
    logic iorD;
    logic memRead;
    logic memWrite;
    logic irWrite;
    logic memtoReg;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic aluSrcA;
    logic [1:0] aluSrcB;
    logic regWrite;
    logic regDst;
    logic instrDone;
    logic illegalOp;
  } ctrl_t;
  function automatic logic isLegal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: Moore control word per state, qualified only by memory ready and DECODE opcode
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic        ready,
  input  logic [5:0]  opCode,
  output ctrl_t       ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp = ALU_ADD;
        ctrl.pcSource = PC_ALU;
        ctrl.irWrite = ready;
        ctrl.pcWrite = ready;
      end
      DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.illegalOp = !isLegal(opCode);
        ctrl.instrDone = !isLegal(opCode);
      end
      MEMADR, ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD = 1'b1;
      end
      MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD = 1'b1;
        ctrl.instrDone = ready;
      end
      EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.aluOp = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource = PC_ALUOUT;
        ctrl.instrDone = 1'b1;
      end
      ADDIWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      JUMP: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSource = PC_JUMP;
        ctrl.instrDone = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: state register and sequencing for the multi-cycle MIPS datapath
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_MEM = 1,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op_code,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);
  state_t cur;
  ctrl_t ctrl;
  logic ready;
  assign ready = (WAIT_MEM != 0) ? mem_ready : 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= RST;
    else
      case (cur)
        RST: cur <= FETCH;
        FETCH: cur <= ready ? DECODE : FETCH;
        DECODE:
          case (op_code)
            OP_R: cur <= EXEC;
            OP_LW, OP_SW: cur <= MEMADR;
            OP_BEQ: cur <= BRANCH;
            OP_ADDI: cur <= ADDIEX;
            OP_J: cur <= JUMP;
            default: cur <= FETCH;
          endcase
        MEMADR: cur <= (op_code == OP_SW) ? MEMWR : MEMRD;
        MEMRD: cur <= ready ? MEMWB : MEMRD;
        MEMWR: cur <= ready ? FETCH : MEMWR;
        EXEC: cur <= ALUWB;
        ADDIEX: cur <= ADDIWB;
        MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: cur <= FETCH;
        default: cur <= RST;
      endcase
  mips_ctrl_outdec u_outdec (.state(cur), .ready(ready), .opCode(op_code), .ctrl(ctrl));
  assign PCWrite = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD = ctrl.iorD;
  assign MemRead = ctrl.memRead;
  assign MemWrite = ctrl.memWrite;
  assign IRWrite = ctrl.irWrite;
  assign MemtoReg = ctrl.memtoReg;
  assign PCSource = ctrl.pcSource;
  assign ALUOp = ctrl.aluOp;
  assign ALUSrcA = ctrl.aluSrcA;
  assign ALUSrcB = ctrl.aluSrcB;
  assign RegWrite = ctrl.regWrite;
  assign RegDst = ctrl.regDst;
  assign instr_done = ctrl.instrDone;
  assign illegal_op = ctrl.illegalOp;
  assign state = STATE_W'(cur);
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle checks of state and the full control word
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op_code = 6'b0;
  logic mem_ready = 1'b1;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [3:0] state;
  logic [17:0] obs;
  int compared = 0;
  int mismatched = 0;
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst,instr_done,illegal_op}
  localparam logic [17:0] V_ZERO   = 18'b0;
  localparam logic [17:0] V_FETCHR = 18'b1_0_0_1_0_1_0_00_00_0_01_0_0_0_0;
  localparam logic [17:0] V_FETCHW = 18'b0_0_0_1_0_0_0_00_00_0_01_0_0_0_0;
  localparam logic [17:0] V_DEC    = 18'b0_0_0_0_0_0_0_00_00_0_11_0_0_0_0;
  localparam logic [17:0] V_DECILL = 18'b0_0_0_0_0_0_0_00_00_0_11_0_0_1_1;
  localparam logic [17:0] V_ADR    = 18'b0_0_0_0_0_0_0_00_00_1_10_0_0_0_0;
  localparam logic [17:0] V_MEMRD  = 18'b0_0_1_1_0_0_0_00_00_0_00_0_0_0_0;
  localparam logic [17:0] V_MEMWB  = 18'b0_0_0_0_0_0_1_00_00_0_00_1_0_1_0;
  localparam logic [17:0] V_MEMWRW = 18'b0_0_1_0_1_0_0_00_00_0_00_0_0_0_0;
  localparam logic [17:0] V_MEMWRR = 18'b0_0_1_0_1_0_0_00_00_0_00_0_0_1_0;
  localparam logic [17:0] V_EXEC   = 18'b0_0_0_0_0_0_0_00_10_1_00_0_0_0_0;
  localparam logic [17:0] V_ALUWB  = 18'b0_0_0_0_0_0_0_00_00_0_00_1_1_1_0;
  localparam logic [17:0] V_BRANCH = 18'b0_1_0_0_0_0_0_01_01_1_00_0_0_1_0;
  localparam logic [17:0] V_ADDIWB = 18'b0_0_0_0_0_0_0_00_00_0_00_1_0_1_0;
  localparam logic [17:0] V_JUMP   = 18'b1_0_0_0_0_0_0_10_00_0_00_0_0_1_0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op_code(op_code), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done, illegal_op};
  always #5 clk = ~clk;

  task automatic test_reset();
    #1 reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      compared++;
      if (state !== 4'(RST)) begin mismatched++; $display("FAIL reset_state cyc%0d: got %0d want %0d", i, state, RST); end
      compared++;
      if (obs !== V_ZERO) begin mismatched++; $display("FAIL reset_outputs cyc%0d: got %b want %b", i, obs, V_ZERO); end
    end
    reset = 1'b0;
    #1;
    compared++;
    if (state !== 4'(RST)) begin mismatched++; $display("FAIL release_state: got %0d want %0d", state, RST); end
    @(negedge clk);
    #1;
    compared++;
    if (state !== 4'(FETCH)) begin mismatched++; $display("FAIL first_fetch_state: got %0d want %0d", state, FETCH); end
    compared++;
    if (obs !== V_FETCHR) begin mismatched++; $display("FAIL first_fetch_outputs: got %b want %b", obs, V_FETCHR); end
  endtask

  task automatic test_lw();
    state_t es [5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
    logic [17:0] ev [5] = '{V_FETCHR, V_DEC, V_ADR, V_MEMRD, V_MEMWB};
    op_code = OP_LW;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      compared++;
      if (state !== 4'(es[i])) begin mismatched++; $display("FAIL lw_state cyc%0d: got %0d want %0d", i, state, es[i]); end
      compared++;
      if (obs !== ev[i]) begin mismatched++; $display("FAIL lw_outputs cyc%0d: got %b want %b", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_wait();
    state_t es [6] = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR};
    logic rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [17:0] ev [6] = '{V_FETCHR, V_DEC, V_ADR, V_MEMWRW, V_MEMWRW, V_MEMWRR};
    op_code = OP_SW;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rd[i];
      #1;
      compared++;
      if (state !== 4'(es[i])) begin mismatched++; $display("FAIL sw_state cyc%0d: got %0d want %0d", i, state, es[i]); end
      compared++;
      if (obs !== ev[i]) begin mismatched++; $display("FAIL sw_outputs cyc%0d: got %b want %b", i, obs, ev[i]); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_r_addi();
    state_t es [9] = '{FETCH, DECODE, EXEC, ALUWB, FETCH, FETCH, DECODE, ADDIEX, ADDIWB};
    logic rd [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [17:0] ev [9] = '{V_FETCHR, V_DEC, V_EXEC, V_ALUWB, V_FETCHW, V_FETCHR, V_DEC, V_ADR, V_ADDIWB};
    for (int i = 0; i < 9; i++) begin
      op_code = (i < 4) ? OP_R : OP_ADDI;
      mem_ready = rd[i];
      #1;
      compared++;
      if (state !== 4'(es[i])) begin mismatched++; $display("FAIL r_addi_state cyc%0d: got %0d want %0d", i, state, es[i]); end
      compared++;
      if (obs !== ev[i]) begin mismatched++; $display("FAIL r_addi_outputs cyc%0d: got %b want %b", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    state_t es [8] = '{FETCH, DECODE, BRANCH, FETCH, DECODE, JUMP, FETCH, DECODE};
    logic [5:0] op [8] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J, 6'b111111, 6'b111111};
    logic [17:0] ev [8] = '{V_FETCHR, V_DEC, V_BRANCH, V_FETCHR, V_DEC, V_JUMP, V_FETCHR, V_DECILL};
    for (int i = 0; i < 8; i++) begin
      op_code = op[i];
      mem_ready = 1'b1;
      #1;
      compared++;
      if (state !== 4'(es[i])) begin mismatched++; $display("FAIL b2b_state cyc%0d: got %0d want %0d", i, state, es[i]); end
      compared++;
      if (obs !== ev[i]) begin mismatched++; $display("FAIL b2b_outputs cyc%0d: got %b want %b", i, obs, ev[i]); end
      @(negedge clk);
    end
    #1;
    compared++;
    if (state !== 4'(FETCH)) begin mismatched++; $display("FAIL illegal_next_state: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_reset_mid();
    state_t es [5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD};
    logic rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [17:0] ev [5] = '{V_FETCHR, V_DEC, V_ADR, V_MEMRD, V_MEMRD};
    op_code = OP_LW;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #1;
      compared++;
      if (state !== 4'(es[i])) begin mismatched++; $display("FAIL midrst_state cyc%0d: got %0d want %0d", i, state, es[i]); end
      compared++;
      if (obs !== ev[i]) begin mismatched++; $display("FAIL midrst_outputs cyc%0d: got %b want %b", i, obs, ev[i]); end
      if (i < 4) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (obs !== V_ZERO) begin mismatched++; $display("FAIL async_reset_outputs: got %b want %b", obs, V_ZERO); end
    compared++;
    if (state !== 4'(RST)) begin mismatched++; $display("FAIL async_reset_state: got %0d want %0d", state, RST); end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    compared++;
    if (state !== 4'(FETCH)) begin mismatched++; $display("FAIL restart_state: got %0d want %0d", state, FETCH); end
    compared++;
    if (obs !== V_FETCHR) begin mismatched++; $display("FAIL restart_outputs: got %b want %b", obs, V_FETCHR); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_r_addi();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
